pc_fetch_seq: RTL and testbench
===============================

# pc_fetch_seq

Instruction-fetch sequencer that drives the `pc_ctrl`/`pc_in` command port of the parameterized program counter and consumes its `pc_out` value. It issues a memory read at the current PC and holds the returned word for a downstream consumer under a valid/ready handshake. On each accepted instruction it commands a PC increment. It also accepts absolute or PC-relative branch redirects from the execute stage.

## Interface
- `d_width`, 4: PC and address width; must match the program counter's `d_width`.
- `i_width`, 8: instruction word width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `clr`  in  1  asynchronous, active-high reset.
- `pc_val`  in  d_width  current PC; connects to the program counter's `pc_out`.
- `pc_ctrl`  out  2  command to the program counter: 00 hold, 01 load, 10 increment, 11 add `pc_in`.
- `pc_in`  out  d_width  load value or offset for the program counter; 0 when `pc_ctrl` is 00 or 10.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  d_width  read address; equals `pc_val` while `mem_req`=1, 0 otherwise.
- `mem_ack`  in  1  single-cycle pulse; `mem_data` is valid in the same cycle.
- `mem_data`  in  i_width  fetched word.
- `instr_out`  out  i_width  held instruction.
- `instr_valid`  out  1  `instr_out` is available to the consumer.
- `instr_ready`  in  1  consumer accepts; a transfer occurs when `instr_valid`=1 and `instr_ready`=1.
- `br_req`  in  1  single-cycle branch request.
- `br_rel`  in  1  1: offset relative to `pc_val`; 0: absolute target.
- `br_target`  in  d_width  target address or two's-complement offset.
- `halt`  in  1  level; stops new fetches.
- `busy`  out  1  1 in FETCH or ISSUE.

## Operation
- States: IDLE, FETCH, ISSUE.
- Branch pend register: `pend`, `pend_rel`, `pend_tgt`.
  - `br_req`=1 loads it on the next edge. The last request wins if one is already pending.
  - The pend register is visible one cycle after `br_req`.
- Redirect cycle: while `pend`=1, the first cycle in IDLE, in ISSUE, or in FETCH with `mem_ack`=1 is a redirect cycle. In it:
  - `pc_ctrl` = `pend_rel` ? 11 : 01.
  - `pc_in` = `pend_tgt`.
  - `pend` clears at the edge.
  - If `br_req`=1 in the same cycle, the new request re-sets `pend`.
- IDLE:
  - `mem_req`=0.
  - Goes to FETCH when `halt`=0 (after any redirect cycle).
  - Otherwise stays in IDLE.
- FETCH:
  - `mem_req`=1 and `mem_addr`=`pc_val`, held stable until `mem_ack`.
  - On `mem_ack` with `pend`=0: `instr_out` <= `mem_data`, and the state goes to ISSUE.
  - On `mem_ack` with `pend`=1: the data is discarded and the redirect is applied. The state goes to FETCH, or to IDLE if `halt`=1.
- ISSUE:
  - `instr_valid` = `!pend`, combinational from registers.
  - On transfer: `pc_ctrl`=10. The state goes to FETCH, or to IDLE if `halt`=1.
  - With `pend`=1: the held word is dropped, never transferred, and the redirect is applied. The state goes to FETCH, or to IDLE if `halt`=1.
  - `instr_out` is stable while `instr_valid`=1.
- `mem_ack` outside FETCH is ignored.
- `halt` never aborts an in-flight fetch or a held instruction.
- PC arithmetic is performed by the program counter modulo 2^d_width. A relative offset is applied to the address of the last fetched instruction, because the increment has not yet occurred.
- Reset values:
  - State IDLE, `pend`=0.
  - `instr_out`=0, `instr_valid`=0, `mem_req`=0, `mem_addr`=0.
  - `pc_ctrl`=00, `pc_in`=0, `busy`=0.
  - Reset asserted mid-fetch drops `mem_req` immediately. A late `mem_ack` is ignored.

## Timing
- All outputs are decoded from registered state. There is no combinational path from `mem_ack`, `instr_ready` or `br_req` to `mem_req`, `instr_valid` or `busy`.
  - `pc_ctrl` and `pc_in` may depend combinationally on `mem_ack` and `instr_ready` within the cycle.
- The program counter updates on the same edge that leaves the redirect or transfer cycle, so the following FETCH sees the new `pc_val`.
- Steady state with zero-wait memory (ack in the first FETCH cycle) and `instr_ready`=1: one instruction every 2 cycles.
- Branch latency: from the `br_req` pulse to `mem_req` at the new PC is 2 cycles minimum when the block is in ISSUE or IDLE.
- Memory wait states extend FETCH one cycle each. Consumer backpressure extends ISSUE one cycle each.

## Test plan
- Straight line: release `clr` with PC at 0, tie `mem_ack`=1 and `mem_data`=addr+8'h10, hold `instr_ready`=1.
  - Expect `instr_out` = 10, 11, 12, … on alternate cycles.
  - Expect `pc_ctrl`=10 in each transfer cycle.
- Backpressure: hold `instr_ready`=0 for 5 cycles in ISSUE.
  - Expect `instr_valid` to stay 1, `instr_out` to stay stable and `pc_ctrl`=00.
  - Expect a single transfer when `instr_ready` rises.
- Absolute branch: pulse `br_req` with `br_rel`=0 and `br_target`=4'hC while in ISSUE at PC 3.
  - Expect `instr_valid` to drop next cycle with no transfer.
  - Expect `pc_ctrl`=01 and `pc_in`=C, then `mem_addr`=C.
- Relative wrap: PC=4'hE, branch with `br_rel`=1 and offset 4'h3 while FETCH is waiting.
  - Expect the acked data to be discarded and `pc_ctrl`=11 in the ack cycle.
  - Expect the next `mem_addr`=1.
- Halt and reset: assert `halt` during FETCH.
  - Expect the word to still issue and the block to return to IDLE with `mem_req`=0 and `busy`=0.
  - Assert `clr` mid-FETCH: expect `mem_req`=0 immediately and a late `mem_ack` to have no effect.

Source files
------------

// File: rtl/pc_fetch_seq_if.sv
// Signal bundle between the fetch sequencer and its neighbours: the program counter
// command port, the instruction memory read port, the consumer handshake and the execute-stage branch inputs.
`timescale 1ns/1ps

interface pc_fetch_seq_if #(
    parameter int unsigned d_width = 4,
    parameter int unsigned i_width = 8
);
    logic [d_width-1:0] pc_val;
    logic [1:0]         pc_ctrl;
    logic [d_width-1:0] pc_in;

    logic               mem_req;
    logic [d_width-1:0] mem_addr;
    logic               mem_ack;
    logic [i_width-1:0] mem_data;

    logic [i_width-1:0] instr_out;
    logic               instr_valid;
    logic               instr_ready;

    logic               br_req;
    logic               br_rel;
    logic [d_width-1:0] br_target;

    logic               halt;
    logic               busy;

    // Sequencer side
    modport master (
        input  pc_val, mem_ack, mem_data, instr_ready, br_req, br_rel, br_target, halt,
        output pc_ctrl, pc_in, mem_req, mem_addr, instr_out, instr_valid, busy
    );

    // Environment side: program counter, memory, consumer, execute stage
    modport slave (
        output pc_val, mem_ack, mem_data, instr_ready, br_req, br_rel, br_target, halt,
        input  pc_ctrl, pc_in, mem_req, mem_addr, instr_out, instr_valid, busy
    );
endinterface

// File: rtl/pc_fetch_seq.sv
// Instruction-fetch sequencer: reads memory at the current PC, holds the word for the consumer,
// steps the program counter on each transfer and applies pending branch redirects.
`timescale 1ns/1ps

module pc_fetch_seq #(
    parameter int unsigned d_width = 4,
    parameter int unsigned i_width = 8
) (
    input  logic               clk,
    input  logic               clr,
    pc_fetch_seq_if.master     bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_ISSUE = 2'b10
    } state_e;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_LOAD = 2'b01;
    localparam logic [1:0] PC_INC  = 2'b10;
    localparam logic [1:0] PC_ADD  = 2'b11;

    state_e             state_q,    state_d;
    logic               pend_q,     pend_d;
    logic               pend_rel_q, pend_rel_d;
    logic [d_width-1:0] pend_tgt_q, pend_tgt_d;
    logic [i_width-1:0] instr_q,    instr_d;

    logic               redirect_c;
    logic               transfer_c;
    logic [1:0]         pc_ctrl_c;
    logic [d_width-1:0] pc_in_c;

    // State and branch-pend registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            pend_q     <= 1'b0;
            pend_rel_q <= 1'b0;
            pend_tgt_q <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_rel_q <= pend_rel_d;
            pend_tgt_q <= pend_tgt_d;
            instr_q    <= instr_d;
        end
    end

    // Next state, redirect/transfer decode and program counter command
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_rel_d = pend_rel_q;
        pend_tgt_d = pend_tgt_q;
        instr_d    = instr_q;
        redirect_c = 1'b0;
        transfer_c = 1'b0;
        pc_ctrl_c  = PC_HOLD;
        pc_in_c    = '0;

        unique case (state_q)
            ST_IDLE: begin
                redirect_c = pend_q;
                state_d    = bus.halt ? ST_IDLE : ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.mem_ack) begin
                    if (pend_q) begin
                        redirect_c = 1'b1;
                        state_d    = bus.halt ? ST_IDLE : ST_FETCH;
                    end else begin
                        instr_d = bus.mem_data;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (pend_q) begin
                    redirect_c = 1'b1;
                    state_d    = bus.halt ? ST_IDLE : ST_FETCH;
                end else if (bus.instr_ready) begin
                    transfer_c = 1'b1;
                    state_d    = bus.halt ? ST_IDLE : ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect_c) begin
            pc_ctrl_c = pend_rel_q ? PC_ADD : PC_LOAD;
            pc_in_c   = pend_tgt_q;
            pend_d    = 1'b0;
        end else if (transfer_c) begin
            pc_ctrl_c = PC_INC;
        end

        // A request in the redirect cycle re-arms the pend register; the newest request wins
        if (bus.br_req) begin
            pend_d     = 1'b1;
            pend_rel_d = bus.br_rel;
            pend_tgt_d = bus.br_target;
        end
    end

    assign bus.pc_ctrl     = pc_ctrl_c;
    assign bus.pc_in       = pc_in_c;
    assign bus.mem_req     = (state_q == ST_FETCH);
    assign bus.mem_addr    = (state_q == ST_FETCH) ? bus.pc_val : '0;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = (state_q == ST_ISSUE) && !pend_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq with a program counter model, a simple memory and a transfer scoreboard.
`timescale 1ns/1ps

module tb_pc_fetch_seq;

    logic clk;
    logic clr;
    int   total;
    int   bad;
    logic [7:0] exp_q[$];
    logic [3:0] pc_q;

    pc_fetch_seq_if #(.d_width(4), .i_width(8)) bus ();

    pc_fetch_seq #(.d_width(4), .i_width(8)) u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter driven by the sequencer's command port
    always_ff @(posedge clk or posedge clr) begin
        if (clr) pc_q <= 4'h0;
        else begin
            case (bus.pc_ctrl)
                2'b01:   pc_q <= bus.pc_in;
                2'b10:   pc_q <= pc_q + 4'h1;
                2'b11:   pc_q <= pc_q + bus.pc_in;
                default: pc_q <= pc_q;
            endcase
        end
    end

    always_comb bus.pc_val = pc_q;
    always_comb bus.mem_data = 8'(bus.mem_addr) + 8'h10;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.instr_ready = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.br_req      = 1'b0;
        bus.br_rel      = 1'b0;
        bus.br_target   = 4'h0;
        bus.halt        = 1'b0;
        clr             = 1'b1;
        tick();
        tick();
        clr = 1'b0;
    endtask

    // Scoreboard monitor: every transfer pops one expected word
    always @(negedge clk) begin
        if (!clr && bus.instr_valid && bus.instr_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_transfer: got %0h expected none at %0t", bus.instr_out, $time);
            end else begin
                chk("xfer_instr", 32'(bus.instr_out), 32'(exp_q.pop_front()));
                chk("xfer_pc_ctrl", 32'(bus.pc_ctrl), 32'h2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        clr   = 1'b1;
        bus.instr_ready = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.br_req      = 1'b0;
        bus.br_rel      = 1'b0;
        bus.br_target   = 4'h0;
        bus.halt        = 1'b0;
        tick();
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_instr_out", 32'(bus.instr_out), 32'h0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_pc_ctrl", 32'(bus.pc_ctrl), 32'h0);
        chk("rst_pc_in", 32'(bus.pc_in), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);

        // Straight line then backpressure on word 0x13
        do_reset();
        bus.instr_ready = 1'b1;
        bus.mem_ack     = 1'b1;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        repeat (8) tick();
        bus.instr_ready = 1'b0;
        #1;
        chk("bp_valid", 32'(bus.instr_valid), 32'h1);
        chk("bp_instr", 32'(bus.instr_out), 32'h13);
        chk("bp_pc", 32'(bus.pc_val), 32'h3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 32'(bus.instr_valid), 32'h1);
            chk("bp_hold_instr", 32'(bus.instr_out), 32'h13);
            chk("bp_hold_pc_ctrl", 32'(bus.pc_ctrl), 32'h0);
        end
        exp_q.push_back(8'h13);
        bus.instr_ready = 1'b1;
        #1;
        chk("bp_release_pc_ctrl", 32'(bus.pc_ctrl), 32'h2);
        tick();
        chk("bp_next_req", 32'(bus.mem_req), 32'h1);
        chk("bp_next_addr", 32'(bus.mem_addr), 32'h4);
        chk("bp_next_valid", 32'(bus.instr_valid), 32'h0);

        // Absolute branch to C while holding the word from PC 3
        do_reset();
        bus.instr_ready = 1'b1;
        bus.mem_ack     = 1'b1;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        repeat (8) tick();
        bus.instr_ready = 1'b0;
        bus.br_req      = 1'b1;
        bus.br_rel      = 1'b0;
        bus.br_target   = 4'hC;
        #1;
        chk("abs_valid_before", 32'(bus.instr_valid), 32'h1);
        chk("abs_pc", 32'(bus.pc_val), 32'h3);
        tick();
        bus.br_req      = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        chk("abs_valid_drop", 32'(bus.instr_valid), 32'h0);
        chk("abs_pc_ctrl", 32'(bus.pc_ctrl), 32'h1);
        chk("abs_pc_in", 32'(bus.pc_in), 32'hC);
        tick();
        exp_q.push_back(8'h1C);
        chk("abs_mem_req", 32'(bus.mem_req), 32'h1);
        chk("abs_mem_addr", 32'(bus.mem_addr), 32'hC);
        tick();
        chk("abs_issue_instr", 32'(bus.instr_out), 32'h1C);
        tick();

        // IDLE redirect to E, then relative +3 while FETCH waits
        do_reset();
        bus.instr_ready = 1'b1;
        bus.halt        = 1'b1;
        bus.br_req      = 1'b1;
        bus.br_rel      = 1'b0;
        bus.br_target   = 4'hE;
        tick();
        bus.br_req = 1'b0;
        bus.halt   = 1'b0;
        #1;
        chk("idle_redir_pc_ctrl", 32'(bus.pc_ctrl), 32'h1);
        chk("idle_redir_pc_in", 32'(bus.pc_in), 32'hE);
        chk("idle_redir_busy", 32'(bus.busy), 32'h0);
        tick();
        bus.br_req    = 1'b1;
        bus.br_rel    = 1'b1;
        bus.br_target = 4'h3;
        #1;
        chk("rel_wait_addr", 32'(bus.mem_addr), 32'hE);
        tick();
        bus.br_req = 1'b0;
        #1;
        chk("rel_pend_addr", 32'(bus.mem_addr), 32'hE);
        chk("rel_pend_pc_ctrl", 32'(bus.pc_ctrl), 32'h0);
        tick();
        bus.mem_ack = 1'b1;
        #1;
        chk("rel_ack_pc_ctrl", 32'(bus.pc_ctrl), 32'h3);
        chk("rel_ack_pc_in", 32'(bus.pc_in), 32'h3);
        tick();
        exp_q.push_back(8'h11);
        chk("rel_wrap_addr", 32'(bus.mem_addr), 32'h1);
        chk("rel_wrap_valid", 32'(bus.instr_valid), 32'h0);
        tick();
        chk("rel_issue_instr", 32'(bus.instr_out), 32'h11);
        tick();

        // Halt during FETCH, then reset mid-fetch with a late ack
        do_reset();
        bus.instr_ready = 1'b1;
        tick();
        bus.halt = 1'b1;
        #1;
        chk("halt_fetch_busy", 32'(bus.busy), 32'h1);
        chk("halt_fetch_req", 32'(bus.mem_req), 32'h1);
        tick();
        bus.mem_ack = 1'b1;
        exp_q.push_back(8'h10);
        #1;
        chk("halt_ack_pc_ctrl", 32'(bus.pc_ctrl), 32'h0);
        tick();
        bus.mem_ack = 1'b0;
        #1;
        chk("halt_issue_valid", 32'(bus.instr_valid), 32'h1);
        chk("halt_issue_instr", 32'(bus.instr_out), 32'h10);
        tick();
        chk("halt_idle_req", 32'(bus.mem_req), 32'h0);
        chk("halt_idle_busy", 32'(bus.busy), 32'h0);
        chk("halt_idle_pc", 32'(bus.pc_val), 32'h1);
        tick();
        bus.halt = 1'b0;
        #1;
        chk("halt_still_idle", 32'(bus.busy), 32'h0);
        tick();
        chk("resume_req", 32'(bus.mem_req), 32'h1);
        chk("resume_addr", 32'(bus.mem_addr), 32'h1);
        clr = 1'b1;
        #1;
        chk("clr_req_drop", 32'(bus.mem_req), 32'h0);
        chk("clr_busy", 32'(bus.busy), 32'h0);
        chk("clr_addr", 32'(bus.mem_addr), 32'h0);
        tick();
        clr         = 1'b0;
        bus.mem_ack = 1'b1;
        #1;
        chk("late_ack_valid", 32'(bus.instr_valid), 32'h0);
        chk("late_ack_instr", 32'(bus.instr_out), 32'h0);
        tick();
        bus.mem_ack = 1'b0;
        #1;
        chk("after_clr_req", 32'(bus.mem_req), 32'h1);
        chk("after_clr_addr", 32'(bus.mem_addr), 32'h0);
        chk("after_clr_instr", 32'(bus.instr_out), 32'h0);

        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
